// File: rtl/amp_pkg.sv
// Shared constants, types and arithmetic helpers for the multichannel gain stage.
package amp_pkg;

    // Width of the saturation event counter exposed on sat_count.
    localparam int unsigned SAT_CNT_W = 16;

    // Working width for the rounding/clamping helpers. It must hold a full
    // DATA_WIDTH x (COEF_WIDTH+1) signed product.
    localparam int unsigned MATH_W = 64;

    typedef logic signed [MATH_W-1:0] wide_t;

    // Result of a saturating clamp: the clamped value plus a flag that is set
    // when clamping actually changed the value.
    typedef struct packed {
        logic  sat;
        wide_t value;
    } clamp_t;

    // Unity gain for a coefficient with 'frac' fractional bits.
    function automatic logic [31:0] unity_gain(input int unsigned frac);
        return 32'd1 << frac;
    endfunction

    // Round half up, then drop 'frac' fractional bits (arithmetic shift).
    function automatic wide_t round_shift(input wide_t x, input int unsigned frac);
        wide_t half;
        half = 64'sd1 <<< (frac - 1);
        return (x + half) >>> frac;
    endfunction

    // Clamp a signed value into the two's-complement range of 'width' bits.
    function automatic clamp_t sat_clamp(input wide_t x, input int unsigned width);
        wide_t  hi;
        wide_t  lo;
        clamp_t r;
        hi      = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo      = -(64'sd1 <<< (width - 1));
        r.sat   = 1'b0;
        r.value = x;
        if (x > hi) begin
            r.value = hi;
            r.sat   = 1'b1;
        end else if (x < lo) begin
            r.value = lo;
            r.sat   = 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/axis_gain_stage_gain_ramp.sv
// Click-free gain ramp: owns the applied gain and walks it toward the
// effective target by at most RAMP_STEP per frame, never overshooting.
module gain_ramp
    import amp_pkg::*;
#(
    parameter int unsigned COEF_WIDTH = 18,
    parameter int unsigned COEF_FRAC  = 16,
    parameter int unsigned RAMP_STEP  = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [COEF_WIDTH-1:0] target_i,
    input  logic                  ena_sync_i,
    input  logic                  frame_tick_i,
    output logic [COEF_WIDTH-1:0] cur_gain_o
);

    localparam logic [31:0]           UNITY_W = unity_gain(COEF_FRAC);
    localparam logic [COEF_WIDTH-1:0] UNITY   = UNITY_W[COEF_WIDTH-1:0];
    localparam logic [31:0]           STEP_W  = RAMP_STEP;

    logic [COEF_WIDTH-1:0] cur_gain_q;
    logic [COEF_WIDTH-1:0] cur_gain_d;
    logic [COEF_WIDTH-1:0] eff_target;
    logic [COEF_WIDTH-1:0] diff;
    logic [COEF_WIDTH-1:0] step;

    // Next gain: step toward the target (dry when disabled) on each frame tick.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        eff_target = ena_sync_i ? target_i : UNITY;
        cur_gain_d = cur_gain_q;
        if (eff_target > cur_gain_q) begin
            diff = eff_target - cur_gain_q;
        end else begin
            diff = cur_gain_q - eff_target;
        end
        step = (32'(diff) > STEP_W) ? STEP_W[COEF_WIDTH-1:0] : diff;
        if (frame_tick_i) begin
            if (eff_target > cur_gain_q) begin
                cur_gain_d = cur_gain_q + step;
            end else begin
                cur_gain_d = cur_gain_q - step;
            end
        end
    end

    // Applied gain register; restarts from unity on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state is written with non-blocking assignments so
        // every register samples pre-edge values regardless of block order.
        if (!rst_n) begin
            cur_gain_q <= UNITY;
        end else begin
            cur_gain_q <= cur_gain_d;
        end
    end

    assign cur_gain_o = cur_gain_q;

endmodule

// File: rtl/axis_gain_stage.sv
// Multichannel runtime-gain AXI-Stream amplifier: 3-stage pipeline
// (register, multiply, round/saturate) with global stall, frame tracking
// and a per-frame gain ramp.
module axis_gain_stage
    import amp_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 24,
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned COEF_WIDTH = 18,
    parameter int unsigned COEF_FRAC  = 16,
    parameter int unsigned RAMP_STEP  = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ena,
    input  logic [COEF_WIDTH-1:0] gain_coef,
    input  logic [DATA_WIDTH-1:0] s_axis_data,
    input  logic                  s_axis_valid,
    output logic                  s_axis_ready,
    input  logic                  s_axis_last,
    output logic [DATA_WIDTH-1:0] m_axis_data,
    output logic                  m_axis_valid,
    input  logic                  m_axis_ready,
    output logic                  m_axis_last,
    output logic [SAT_CNT_W-1:0]  sat_count,
    output logic                  frame_err
);

    localparam int unsigned     PROD_W  = DATA_WIDTH + COEF_WIDTH + 1;
    localparam int unsigned     CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    // Enable synchroniser and post-reset ready gate.
    logic ena_meta_q;
    logic ena_sync_q;
    logic ready_en_q;

    // Handshake and frame bookkeeping.
    logic            ce;
    logic            accept;
    logic            frame_tick;
    logic [CH_W-1:0] ch_q;
    logic [CH_W-1:0] ch_d;
    logic            frame_err_q;
    logic            frame_err_d;

    logic [COEF_WIDTH-1:0] cur_gain;

    // Pipeline stages.
    logic                     v1_q;
    logic                     l1_q;
    logic [DATA_WIDTH-1:0]    d1_q;
    logic [COEF_WIDTH-1:0]    g1_q;
    logic                     v2_q;
    logic                     l2_q;
    logic signed [PROD_W-1:0] prod2_q;
    logic signed [PROD_W-1:0] prod2_d;
    logic                     v3_q;
    logic                     l3_q;
    logic [DATA_WIDTH-1:0]    data3_q;
    logic [DATA_WIDTH-1:0]    data3_d;
    logic                     sat3_d;
    logic [SAT_CNT_W-1:0]     sat_cnt_q;

    wide_t  prod_ext;
    wide_t  rounded;
    clamp_t clamped;
    logic   unused_hi;

    // The whole pipeline advances together whenever the output slot is free
    // or being drained; the input may only be accepted when it advances.
    assign ce         = m_axis_ready | ~v3_q;
    assign s_axis_ready = ce & ready_en_q;
    assign accept     = s_axis_valid & s_axis_ready;
    assign frame_tick = accept & s_axis_last;

    // Two-flop synchroniser for the asynchronous enable switch, plus the
    // one-cycle ready gate after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ena_meta_q <= 1'b0;
            ena_sync_q <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            ena_meta_q <= ena;
            ena_sync_q <= ena_meta_q;
            ready_en_q <= 1'b1;
        end
    end

    gain_ramp #(
        .COEF_WIDTH (COEF_WIDTH),
        .COEF_FRAC  (COEF_FRAC),
        .RAMP_STEP  (RAMP_STEP)
    ) u_ramp (
        .clk          (clk),
        .rst_n        (rst_n),
        .target_i     (gain_coef),
        .ena_sync_i   (ena_sync_q),
        .frame_tick_i (frame_tick),
        .cur_gain_o   (cur_gain)
    );

    // Channel counter and misalignment detection; a missing last holds the
    // counter at the final channel until the next last resyncs it to zero.
    always_comb begin
        ch_d        = ch_q;
        frame_err_d = frame_err_q;
        if (accept) begin
            if (s_axis_last != (ch_q == LAST_CH)) begin
                frame_err_d = 1'b1;
            end
            if (s_axis_last) begin
                ch_d = '0;
            end else if (ch_q != LAST_CH) begin
                ch_d = ch_q + CH_W'(1);
            end
        end
    end

    // Frame tracking state; the error flag is sticky until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q        <= '0;
            frame_err_q <= 1'b0;
        end else begin
            ch_q        <= ch_d;
            frame_err_q <= frame_err_d;
        end
    end

    // Signed sample times zero-extended (always positive) coefficient.
    assign prod2_d = PROD_W'($signed(d1_q)) * PROD_W'($signed({1'b0, g1_q}));

    // Round half up, drop the fractional bits and clamp to the sample range.
    always_comb begin
        prod_ext = wide_t'(prod2_q);
        rounded  = round_shift(prod_ext, COEF_FRAC);
        clamped  = sat_clamp(rounded, DATA_WIDTH);
        data3_d  = clamped.value[DATA_WIDTH-1:0];
        sat3_d   = clamped.sat;
    end

    // Upper bits of the clamped value are sign copies and carry no information.
    assign unused_hi = ^clamped.value[MATH_W-1:DATA_WIDTH];

    // Pipeline registers; every stage holds while the output is stalled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            l1_q    <= 1'b0;
            d1_q    <= '0;
            g1_q    <= '0;
            v2_q    <= 1'b0;
            l2_q    <= 1'b0;
            prod2_q <= '0;
            v3_q    <= 1'b0;
            l3_q    <= 1'b0;
            data3_q <= '0;
        end else if (ce) begin
            v1_q    <= accept;
            l1_q    <= s_axis_last;
            d1_q    <= s_axis_data;
            g1_q    <= cur_gain;
            v2_q    <= v1_q;
            l2_q    <= l1_q;
            prod2_q <= prod2_d;
            v3_q    <= v2_q;
            l3_q    <= l2_q;
            data3_q <= data3_d;
        end
    end

    // Saturation counter: counts clamped samples entering the output stage
    // and sticks at its maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_cnt_q <= '0;
        end else if (ce && v2_q && sat3_d && (sat_cnt_q != '1)) begin
            sat_cnt_q <= sat_cnt_q + SAT_CNT_W'(1);
        end
    end

    assign m_axis_data  = data3_q;
    assign m_axis_valid = v3_q;
    assign m_axis_last  = l3_q;
    assign sat_count    = sat_cnt_q;
    assign frame_err    = frame_err_q;

endmodule

// File: doc/axis_gain_stage.md
Name: axis_gain_stage

Overview:
Multichannel, runtime-gain AXI-Stream amplifier. It is the successor to the fixed-gain single-channel amp and sits between the I2S/TDM receive path and the DAC serializer. Interleaved channel samples arrive as frames, with s_axis_last marking the last channel of each frame. The gain is programmable at runtime and ramps click-free at frame boundaries. Outputs are rounded and saturated, and the block supports full AXIS backpressure, so it never drops a sample.

Parameters:
DATA_WIDTH, 24, signed two's-complement sample width.
NUM_CH, 2, channels per frame (1..16).
COEF_WIDTH, 18, unsigned gain coefficient width.
COEF_FRAC, 16, coefficient fractional bits; unity = 2**COEF_FRAC.
RAMP_STEP, 4096, maximum change of the applied gain per frame, in coefficient LSBs.

Ports:
clk  in  1  single clock domain.
rst_n  in  1  asynchronous active-low reset.
ena  in  1  amplifier enable from a switch; asynchronous, synchronised internally by 2 flip-flops.
gain_coef  in  COEF_WIDTH  target gain, unsigned, COEF_FRAC fractional bits; quasi-static.
s_axis_data  in  DATA_WIDTH  input sample.
s_axis_valid  in  1  input valid.
s_axis_ready  out  1  input ready.
s_axis_last  in  1  last channel of frame.
m_axis_data  out  DATA_WIDTH  output sample.
m_axis_valid  out  1  output valid.
m_axis_ready  in  1  downstream ready.
m_axis_last  out  1  last channel of frame, delayed with its sample.
sat_count  out  16  number of saturated output samples; sticks at 0xFFFF.
frame_err  out  1  sticky flag: s_axis_last misaligned with NUM_CH.

Behaviour:
- Reset (asynchronous assert, synchronous-safe release):
  - Pipeline valids = 0; m_axis_valid = 0, m_axis_data = 0, m_axis_last = 0.
  - cur_gain = unity; ch_idx = 0.
  - sat_count = 0, frame_err = 0; ena synchroniser = 0.
  - s_axis_ready = 1 one cycle after rst_n deasserts.
- Pipeline: 3 stages (register input, multiply, round/saturate).
  - Global advance: ce = m_axis_ready OR NOT v3; s_axis_ready = ce.
  - Latency is 3 cycles from accepted input to m_axis_valid when there is no stall.
  - Throughput is 1 sample per clock.
  - When stalled, all stages hold; m_axis_valid/data/last stay stable until the handshake (AXIS-compliant). No sample is lost or duplicated.
- Frame tracking: ch_idx increments on each accepted beat and wraps to 0 on an accepted beat with last.
  - frame_err is set if last is accepted with ch_idx != NUM_CH-1, or if ch_idx == NUM_CH-1 is accepted without last.
  - On error, ch_idx resyncs to 0 at the next last.
- Gain ramp:
  - Effective target = gain_coef when ena_sync = 1, else unity (disabling fades to dry).
  - On each accepted beat with last, cur_gain moves toward the target by min(RAMP_STEP, |target - cur_gain|) and never overshoots.
  - The gain for a sample is sampled at stage 1 from cur_gain. Because cur_gain updates only after a frame's last beat, all channels in a frame use identical gain.
- Arithmetic:
  - Product = signed sample × zero-extended coefficient; width DATA_WIDTH+COEF_WIDTH+1.
  - Add 2**(COEF_FRAC-1) (round half up), then arithmetic shift right by COEF_FRAC.
  - Clamp to [-2**(DATA_WIDTH-1), 2**(DATA_WIDTH-1)-1].
  - sat_count increments when a clamped sample advances into stage 3.
- gain_coef = 0 is legal and yields silence. A change to gain_coef mid-frame is picked up only at the next frame boundary.
- Reset mid-stream: in-flight samples are discarded and the ramp restarts from unity.

Decomposition:
- Package amp_pkg holds:
  - the unity-gain constant function of COEF_FRAC;
  - a saturating-clamp function parametrised on width;
  - a round-shift function;
  - the sat_count width constant.
- One sub-module, gain_ramp, owns cur_gain, target selection and step clamping. Its inputs are target, ena_sync and frame_tick.

Test Plan:
- Unity: ena = 1, gain_coef = 0x10000, input 0x100000 with ready held high -> 0x100000 appears 3 cycles later; m_axis_last aligned with input last.
- Rounding, RAMP_STEP = 0x40000 (instant), gain 0x18000: input 3 -> 5; input -3 -> -4; input 0 -> 0.
- Saturation, gain 0x20000 instant: 0x500000 -> 0x7FFFFF; -0x500000 (0xB00000) -> 0x800000; sat_count = 2.
- Ramp, defaults: switch gain_coef from 0x10000 to 0x20000 under continuous stereo frames -> applied gain 0x11000 in frame 1 and 0x20000 from frame 16 on; both channels of each frame are equal. ena -> 0 -> ramps back to 0x10000 over 16 frames.
- Backpressure: random m_axis_ready (~50%) and random s_axis_valid over 1000 samples -> output sequence equals the reference model exactly; data stable while valid && !ready.
- Framing and reset: NUM_CH = 2 with last on the 3rd beat -> frame_err = 1 and sticky. Assert rst_n = 0 mid-stall -> all outputs 0 immediately and cur_gain = unity.
